// File: rtl/bcd_scan_display.sv
// Four-digit BCD event counter with a time-multiplexed 7-segment scan output.
// Per-digit increment cells are chained through their carries; one shared seg7 drives the bus.

module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // {g,f,e,d,c,b,a}, active high; non-BCD codes go dark
    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
    end
endmodule

module bcd_digit (
    input  logic [3:0] d,
    input  logic       inc,
    output logic [3:0] d_nxt,
    output logic       carry
);
    // Anything at or above 9 rolls to 0, so a corrupted digit self-heals
    always_comb begin
        d_nxt = d;
        carry = 1'b0;
        if (inc) begin
            if (d >= 4'd9) begin
                d_nxt = 4'd0;
                carry = 1'b1;
            end else begin
                d_nxt = d + 4'd1;
            end
        end
    end
endmodule

module bcd_scan_display #(
    parameter int SCAN_DIV = 10_000,
    parameter int LZB      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        tick_in,
    input  logic        clear,
    input  logic        hold,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  digit_sel,
    output logic [15:0] bcd_out,
    output logic        overflow
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 4;
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [NUM_LANES-1:0][VEC_W-1:0] bcd_q, bcd_inc;
    logic [NUM_LANES:0]              carry;
    logic [NUM_LANES-1:0]            blank;
    logic [15:0]                     div_q;
    logic [1:0]                      idx_q;
    logic [6:0]                      seg_dec;

    assign carry[0] = tick_in & ~hold;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_dig
        bcd_digit u_dig (
            .d     (bcd_q[g]),
            .inc   (carry[g]),
            .d_nxt (bcd_inc[g]),
            .carry (carry[g+1])
        );
    end

    // A digit blanks only if it and every digit above it are zero; units never blank
    always_comb begin
        blank = '0;
        blank[NUM_LANES-1] = (LZB != 0) && (bcd_q[NUM_LANES-1] == 4'd0);
        for (int k = NUM_LANES - 2; k >= 1; k--)
            blank[k] = blank[k+1] && (bcd_q[k] == 4'd0);
    end

    seg7 u_seg (
        .digit (bcd_q[idx_q]),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            overflow  <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            digit_sel <= 4'b0001;
            seg_out   <= 7'b0111111;
            dp_out    <= 1'b0;
        end else if (ena) begin
            if (clear) begin
                bcd_q    <= '0;
                overflow <= 1'b0;
            end else begin
                bcd_q    <= bcd_inc;
                overflow <= carry[NUM_LANES];
            end
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
            // Select, segments and dp all load from the same index so they never skew
            digit_sel <= 4'b0001 << idx_q;
            seg_out   <= blank[idx_q] ? 7'b0000000 : seg_dec;
            dp_out    <= hold && (idx_q == 2'd0);
        end
    end

    assign bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Random plus directed stimulus for bcd_scan_display, checked every cycle against a
// count/cycle-arithmetic model; two instances cover LZB=1 and LZB=0.

module tb_bcd_scan_display;
    localparam int SD = 4;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, tick_in = 1'b0, clear = 1'b0, hold = 1'b0;
    logic [6:0]  seg_out, seg0;
    logic        dp_out, dp0, overflow, ovf0;
    logic [3:0]  digit_sel, sel0;
    logic [15:0] bcd_out, bcd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(SD), .LZB(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick_in(tick_in), .clear(clear), .hold(hold),
        .seg_out(seg_out), .dp_out(dp_out), .digit_sel(digit_sel), .bcd_out(bcd_out),
        .overflow(overflow)
    );

    bcd_scan_display #(.SCAN_DIV(SD), .LZB(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick_in(tick_in), .clear(clear), .hold(hold),
        .seg_out(seg0), .dp_out(dp0), .digit_sel(sel0), .bcd_out(bcd0),
        .overflow(ovf0)
    );

    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Model: count as an integer; scan slot derived from enabled cycles since reset
    int         m_cnt = 0, m_ecyc = 0;
    logic [3:0] m_sel = 4'b0001;
    logic [6:0] m_seg = 7'h3F, m_seg0 = 7'h3F;
    logic       m_dp = 1'b0, m_ovf = 1'b0;
    int         mk, mp, mdg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_ecyc <= 0; m_sel <= 4'b0001;
            m_seg <= 7'h3F; m_seg0 <= 7'h3F; m_dp <= 1'b0; m_ovf <= 1'b0;
        end else if (ena) begin
            mk  = (m_ecyc / SD) % 4;
            mp  = pow10(mk);
            mdg = (m_cnt / mp) % 10;
            m_sel  <= 4'(1 << mk);
            m_seg  <= (mk > 0 && m_cnt < mp) ? 7'h00 : glyph[mdg];
            m_seg0 <= glyph[mdg];
            m_dp   <= (mk == 0) && hold;
            m_ecyc <= m_ecyc + 1;
            if (clear) begin
                m_cnt <= 0; m_ovf <= 1'b0;
            end else if (tick_in && !hold) begin
                m_ovf <= (m_cnt == 9999);
                m_cnt <= (m_cnt + 1) % 10000;
            end else begin
                m_ovf <= 1'b0;
            end
        end
    end

    // Literal pins: mask bits {seg0, seg, sel, dp, ovf, bcd}
    logic [5:0]  pin_m = '0;
    logic [15:0] pin_bcd;
    logic [3:0]  pin_sel;
    logic [6:0]  pin_seg, pin_seg0;
    logic        pin_dp, pin_ovf;
    string       pin_name = "";

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("bcd_out", bcd_out, to_bcd(m_cnt));
        cmp("overflow", 16'(overflow), 16'(m_ovf));
        cmp("digit_sel", 16'(digit_sel), 16'(m_sel));
        cmp("seg_out", 16'(seg_out), 16'(m_seg));
        cmp("dp_out", 16'(dp_out), 16'(m_dp));
        cmp("seg_out_nolzb", 16'(seg0), 16'(m_seg0));
        cmp("sel_nolzb", 16'(sel0), 16'(m_sel));
        if (pin_m[0]) cmp({pin_name, ".bcd"}, bcd_out, pin_bcd);
        if (pin_m[1]) cmp({pin_name, ".ovf"}, 16'(overflow), 16'(pin_ovf));
        if (pin_m[2]) cmp({pin_name, ".dp"}, 16'(dp_out), 16'(pin_dp));
        if (pin_m[3]) cmp({pin_name, ".sel"}, 16'(digit_sel), 16'(pin_sel));
        if (pin_m[4]) cmp({pin_name, ".seg"}, 16'(seg_out), 16'(pin_seg));
        if (pin_m[5]) cmp({pin_name, ".seg0"}, 16'(seg0), 16'(pin_seg0));
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin_chk(input string nm, input logic [5:0] m);
        pin_name = nm;
        pin_m = m;
        @(negedge clk);
        #1 pin_m = '0;
    endtask

    task automatic pin_reset(input string nm);
        pin_bcd = 16'h0000; pin_ovf = 1'b0; pin_dp = 1'b0;
        pin_sel = 4'b0001;  pin_seg = 7'b0111111;
        pin_chk(nm, 6'b001111 | 6'b010000);
    endtask

    task automatic ticks(input int n);
        tick_in = 1'b1;
        run(n);
        tick_in = 1'b0;
    endtask

    initial begin
        run(3);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pin_reset("reset");
        run(4);  pin_sel = 4'b0001; pin_chk("scan_e4", 6'b001000);
        run(1);  pin_sel = 4'b0010; pin_chk("scan_e5", 6'b001000);
        run(4);  pin_sel = 4'b0100; pin_chk("scan_e9", 6'b001000);
        run(4);  pin_sel = 4'b1000; pin_chk("scan_e13", 6'b001000);
        run(4);  pin_sel = 4'b0001; pin_chk("scan_e17", 6'b001000);

        // Carry chain and wrap
        ticks(999);
        pin_bcd = 16'h0999; pin_chk("pre999", 6'b000001);
        ticks(1);
        pin_bcd = 16'h1000; pin_ovf = 1'b0; pin_chk("carry1000", 6'b000011);
        ticks(8999);
        pin_bcd = 16'h9999; pin_ovf = 1'b0; pin_chk("at9999", 6'b000011);
        ticks(1);
        pin_bcd = 16'h0000; pin_ovf = 1'b1; pin_chk("wrap", 6'b000011);
        run(1);
        pin_ovf = 1'b0; pin_chk("wrap_end", 6'b000010);

        // Clear beats tick; hold blocks ticks and lights dp on units slot
        ticks(42);
        pin_bcd = 16'h0042; pin_chk("at42", 6'b000001);
        clear = 1'b1; tick_in = 1'b1; run(1); clear = 1'b0; tick_in = 1'b0;
        pin_bcd = 16'h0000; pin_ovf = 1'b0; pin_chk("clr_tick", 6'b000011);
        ticks(5);
        hold = 1'b1;
        repeat (3) begin ticks(1); run(1); end
        pin_bcd = 16'h0005; pin_chk("hold", 6'b000001);
        for (int i = 0; i < 2 * SD; i++) begin
            run(1);
            if (m_sel == 4'b0001) begin
                pin_dp = 1'b1; pin_chk("hold_dp", 6'b000100);
                break;
            end
        end
        hold = 1'b0;

        // Blanking at count 0007, both LZB settings
        clear = 1'b1; run(1); clear = 1'b0;
        ticks(7);
        run(2);
        for (int i = 0; i < 4 * SD; i++) begin
            run(1);
            if (m_sel == 4'b0001) begin pin_seg = 7'b0000111; pin_seg0 = 7'b0000111; end
            else begin pin_seg = 7'b0000000; pin_seg0 = 7'b0111111; end
            if (i % SD == 1) pin_chk("blank", 6'b110000);
        end

        // Enable freeze mid-slot with ticks toggling
        run(SD + 1);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_in = 1'($urandom_range(0, 1));
            clear   = (i == 10);
            run(1);
        end
        tick_in = 1'b0; clear = 1'b0;
        pin_bcd = 16'h0007; pin_chk("freeze", 6'b000001);
        ena = 1'b1;
        run(3 * SD);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ena     = ($urandom_range(0, 9) != 0);
            tick_in = 1'($urandom_range(0, 1));
            hold    = ($urandom_range(0, 4) == 0);
            clear   = ($urandom_range(0, 49) == 0);
            run(1);
        end
        ena = 1'b1; tick_in = 1'b0; hold = 1'b0; clear = 1'b0;

        // Async reset between edges at count 1234
        clear = 1'b1; run(1); clear = 1'b0;
        ticks(1234);
        run(SD + 1);
        pin_bcd = 16'h1234; pin_chk("at1234", 6'b000001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        pin_reset("async_rst");
        run(2);
        rst_n = 1'b1;
        run(2 * SD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream display stage for the seconds counter. Consumes the one-cycle rollover tick from the counter and accumulates it in a 4-digit BCD count (0000–9999). It then time-multiplexes the four digits onto one shared 7-segment bus with one-hot digit selects. It reuses the existing `seg7` decoder for the digit-to-segment mapping.

## Interface

Parameters:
- `SCAN_DIV`, default 10_000: clocks per digit slot (1 kHz slot rate at 10 MHz clk); legal range 2 to 2^16−1.
- `LZB`, default 1: leading-zero blanking enable (1 = on).

Ports:
- `clk`  input  1  single system clock.
- `rst_n`  input  1  reset: asynchronous, active-low.
- `ena`  input  1  design enable; low freezes all state.
- `tick_in`  input  1  one-cycle count pulse from the seconds counter.
- `clear`  input  1  synchronous clear of the BCD count.
- `hold`  input  1  ignore `tick_in` while high; the display keeps scanning.
- `seg_out`  output  7  segments {g,f,e,d,c,b,a}, active high.
- `dp_out`  output  1  decimal point, active high.
- `digit_sel`  output  4  one-hot digit enable, active high; bit 0 = units.
- `bcd_out`  output  16  count as {thousands, hundreds, tens, units}.
- `overflow`  output  1  one-cycle pulse when the count wraps from 9999 to 0000.

## Operation

- All registers reset asynchronously on `rst_n` low. Reset values:
  - `bcd_out` = 0.
  - scan divider = 0, scan index = 0.
  - `digit_sel` = 4'b0001.
  - `seg_out` = 7'b0111111 (glyph "0").
  - `dp_out` = 0, `overflow` = 0.
- When `ena` is low, every register holds its value and outputs are frozen; `tick_in` and `clear` are ignored.
- Count priority, evaluated each enabled cycle:
  1. `clear` high: count goes to 0000 and no overflow pulse is produced, even if `tick_in` is also high.
  2. Otherwise, `tick_in` high and `hold` low: count increments.
- Increment rules:
  - Units 0–9; a carry into the next digit occurs only when the lower digit is 9 and rolls over to 0. The same rule applies through tens, hundreds and thousands.
  - 9999 + 1 = 0000, and `overflow` = 1 for exactly that next cycle.
- Digit fields never hold values A–F. If a non-BCD value is ever observed, the increment forces that digit to 0 and carries.
- Scan divider:
  - Counts 0 to SCAN_DIV−1. At the terminal value it returns to 0 and the scan index advances 0→1→2→3→0.
  - The divider and scan index run regardless of `hold` and `clear`.
- Output registers, loaded every enabled cycle from the current scan index:
  - `digit_sel` = one-hot of the index.
  - `seg_out` = `seg7` decode of the selected BCD digit, or 7'b0000000 when that digit is blanked.
  - `dp_out` = `hold` while index = 0, otherwise 0.
- Leading-zero blanking (LZB=1):
  - Digit k (k = 3, 2, 1) is blanked when it and all higher digits are 0.
  - Units are never blanked.
  - `digit_sel` stays asserted for a blanked digit.
  - With LZB=0, no digit is ever blanked.

## Timing

- Latency from `tick_in` to `bcd_out`: 1 clock. `tick_in` sampled high at edge N gives the new `bcd_out` after edge N.
- `overflow` goes high on the same edge that `bcd_out` becomes 0000, and clears on the following edge.
- `clear` takes effect on the edge where it is sampled.
- `digit_sel`, `seg_out` and `dp_out` are fully registered and always change on the same edge, so there is no segment/select skew.
  - When the scan index changes at edge N, all three outputs reflect the new index after edge N+1 (1-cycle output latency).
- A count change appears on `seg_out` within 1 clock if the changed digit is currently selected; otherwise it appears when that digit's slot comes up.
- Each digit is displayed for exactly SCAN_DIV cycles; a full frame is 4×SCAN_DIV cycles.
- Reset asserted mid-slot returns everything to reset values immediately. The first slot after reset release lasts the full SCAN_DIV cycles.
- Back-to-back `tick_in` (high on every cycle) increments once per cycle with no lost counts.

## Test plan

- Reset: hold `rst_n` low, release with SCAN_DIV=4 → `bcd_out`=0, `digit_sel`=0001, `seg_out`=0111111. `digit_sel` reaches 0010 on the 5th edge after release, then 0100, 1000, and 0001 again after 16 cycles.
- Carry chain: preload 0999 using 999 ticks, then one tick → `bcd_out`=16'h1000 one cycle later, no overflow. Then 9000 more ticks → 16'h0000 with `overflow` high for exactly 1 cycle.
- Priority: at count 0042, assert `clear` and `tick_in` together → 0000 with no overflow. At count 0005 with `hold` high, pulse tick 3 times → stays 0005 and `dp_out`=1 during the units slot.
- Blanking: count 0007 with LZB=1 → units `seg_out`=0000111, tens/hundreds/thousands `seg_out`=0000000. Same count with LZB=0 → leading slots show 0111111.
- Enable freeze: drop `ena` for 20 cycles mid-slot while pulsing `tick_in` → all outputs and count unchanged. After `ena` returns, the slot completes its remaining cycles.
- Async reset mid-operation: assert `rst_n` low between clock edges at count 1234 → outputs reach reset values before the next edge.
